// File: rtl/softplus_delta_stage_if.sv
// Handshake bundle for the softplus delta stage: input pairs, delta output
// stream and the per-vector sum pulse.
interface softplus_delta_stage_if #(
  parameter int IDX_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_err;
  logic [15:0]      in_grad;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_delta;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             sum_valid;
  logic [15:0]      sum_out;

  modport master (
    output in_valid, in_err, in_grad, out_ready,
    input  in_ready, out_valid, out_delta, out_idx, out_last, sum_valid, sum_out
  );

  modport slave (
    input  in_valid, in_err, in_grad, out_ready,
    output in_ready, out_valid, out_delta, out_idx, out_last, sum_valid, sum_out
  );
endinterface

// File: rtl/softplus_delta_stage.sv
// Backprop delta stage: delta = err * grad' through a two-stage
// multiply / round / saturate pipeline, with a saturated per-vector sum.
module softplus_delta_stage #(
  parameter int VEC_LEN = 20,
  parameter int IDX_W   = 5
) (
  input logic                   clk,
  input logic                   rst,
  softplus_delta_stage_if.slave bus
);

  localparam int ACC_W = 16 + IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic signed [25:0] RND_MAX = 26'(32767);
  localparam logic signed [25:0] RND_MIN = 26'(-32768);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-32768);

  logic                    advance;
  logic                    out_fire;
  logic                    s1_valid;
  logic signed [32:0]      s1_prod;
  logic signed [33:0]      rounded_sum;
  logic signed [25:0]      rounded;
  logic [15:0]             delta_next;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_total;
  logic [15:0]             sum_next;

  // Global stall: every stage moves together whenever the output register can move.
  assign advance      = !bus.out_valid || bus.out_ready;
  assign out_fire     = bus.out_valid && bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_idx  = idx;
  assign bus.out_last = (idx == LAST_IDX);

  always_comb begin
    rounded_sum = $signed({s1_prod[32], s1_prod}) + 34'sd128;
    rounded     = rounded_sum[33:8];
    if (rounded > RND_MAX) begin
      delta_next = 16'h7FFF;
    end else if (rounded < RND_MIN) begin
      delta_next = 16'h8000;
    end else begin
      delta_next = rounded[15:0];
    end

    acc_total = acc + ACC_W'($signed(bus.out_delta));
    if (acc_total > ACC_MAX) begin
      sum_next = 16'h7FFF;
    end else if (acc_total < ACC_MIN) begin
      sum_next = 16'h8000;
    end else begin
      sum_next = acc_total[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_prod       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_delta <= '0;
      idx           <= '0;
      acc           <= '0;
      bus.sum_valid <= 1'b0;
      bus.sum_out   <= '0;
    end else begin
      bus.sum_valid <= 1'b0;

      if (advance) begin
        s1_valid      <= bus.in_valid;
        bus.out_valid <= s1_valid;
        if (bus.in_valid) begin
          s1_prod <= $signed(bus.in_err) * $signed({1'b0, bus.in_grad});
        end
        if (s1_valid) begin
          bus.out_delta <= delta_next;
        end
      end

      // The last element closes the vector: publish the sum and restart from zero.
      if (out_fire) begin
        if (bus.out_last) begin
          idx           <= '0;
          acc           <= '0;
          bus.sum_out   <= sum_next;
          bus.sum_valid <= 1'b1;
        end else begin
          idx <= idx + IDX_W'(1);
          acc <= acc_total;
        end
      end
    end
  end

endmodule

// File: tb/tb_softplus_delta_stage.sv
// Randomized self-checking bench for softplus_delta_stage against an
// arithmetic reference model of delta, index and per-vector sum.
module tb_softplus_delta_stage;

  localparam int VEC_LEN = 20;
  localparam int IDX_W   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  softplus_delta_stage_if #(.IDX_W(IDX_W)) bus ();

  softplus_delta_stage #(.VEC_LEN(VEC_LEN), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  int          model_idx = 0;
  longint      model_acc = 0;
  logic        sum_due = 1'b0;
  logic [15:0] exp_sum = '0;
  logic [15:0] last_sum = '0;
  logic        hold_valid = 1'b0;
  logic [15:0] hold_delta;
  logic [IDX_W-1:0] hold_idx;
  logic        hold_last;
  logic [15:0] mon_d;
  int          ready_mode = 0;
  logic        ready_level = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  // Q8.8 x Q8.8 product, rounded half-up to Q8.8 by floor((p + 128) / 256).
  function automatic logic [15:0] ref_delta(input logic [15:0] e, input logic [15:0] g);
    longint prod;
    longint num;
    longint q;
    prod = longint'($signed(e)) * longint'(g);
    num  = prod + 128;
    q    = (num >= 0) ? num / 256 : -((-num + 255) / 256);
    return sat16(q);
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    bus.out_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : ready_level;
  end

  // Monitor: observes both handshakes between edges and scores every transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_idx  = 0;
      model_acc  = 0;
      sum_due    = 1'b0;
      hold_valid = 1'b0;
    end else begin
      if (sum_due) begin
        checkOutput("sum_valid_pulse", 32'(bus.sum_valid), 32'd1);
        checkOutput("sum_out", 32'(bus.sum_out), 32'(exp_sum));
        last_sum = bus.sum_out;
        sum_due  = 1'b0;
      end else if (bus.sum_valid) begin
        checkOutput("sum_valid_spurious", 32'(bus.sum_valid), 32'd0);
      end

      if (hold_valid) begin
        checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("stall_delta", 32'(bus.out_delta), 32'(hold_delta));
        checkOutput("stall_idx", 32'(bus.out_idx), 32'(hold_idx));
        checkOutput("stall_last", 32'(bus.out_last), 32'(hold_last));
        hold_valid = 1'b0;
      end

      if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_delta(bus.in_err, bus.in_grad));

      if (bus.out_valid) begin
        if (!bus.out_ready) begin
          hold_valid = 1'b1;
          hold_delta = bus.out_delta;
          hold_idx   = bus.out_idx;
          hold_last  = bus.out_last;
        end else if (exp_q.size() == 0) begin
          checkOutput("out_spurious", 32'(bus.out_valid), 32'd0);
        end else begin
          mon_d = exp_q.pop_front();
          checkOutput("out_delta", 32'(bus.out_delta), 32'(mon_d));
          checkOutput("out_idx", 32'(bus.out_idx), 32'(model_idx));
          checkOutput("out_last", 32'(bus.out_last), 32'(model_idx == VEC_LEN - 1));
          model_acc += longint'($signed(mon_d));
          if (model_idx == VEC_LEN - 1) begin
            exp_sum   = sat16(model_acc);
            sum_due   = 1'b1;
            model_acc = 0;
          end
          model_idx = (model_idx + 1) % VEC_LEN;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] e, input logic [15:0] g);
    int waited = 0;
    @(posedge clk);
    #2;
    bus.in_valid = 1'b1;
    bus.in_err   = e;
    bus.in_grad  = g;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 200) begin
        checkOutput("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDrain();
    int n = 0;
    idleCycles(2);
    while ((exp_q.size() != 0 || sum_due) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkOutput("drain", 32'(exp_q.size() == 0 && !sum_due), 32'd1);
  endtask

  task automatic resetDut();
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic singleCheck(input string tag, input logic [15:0] e, input logic [15:0] g,
                             input logic [15:0] want);
    applyStimulus(e, g);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput(tag, 32'(bus.out_delta), 32'(want));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0;
    logic [15:0] g;
    bus.in_valid = 1'b0;
    bus.in_err   = '0;
    bus.in_grad  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_delta", 32'(bus.out_delta), 32'd0);
    checkOutput("rst_out_idx", 32'(bus.out_idx), 32'd0);
    checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
    checkOutput("rst_sum_out", 32'(bus.sum_out), 32'd0);

    singleCheck("one_x_grad", 16'h0100, 16'h0035, 16'h0035);
    checkOutput("first_idx", 32'(bus.out_idx), 32'd1);
    singleCheck("neg_one_x_grad", 16'hFF00, 16'h0035, 16'hFFCB);
    singleCheck("round_half_up", 16'h0001, 16'h0080, 16'h0001);
    singleCheck("round_neg_half", 16'hFFFF, 16'h0080, 16'h0000);
    singleCheck("sat_pos", 16'h7FFF, 16'h0200, 16'h7FFF);
    singleCheck("sat_neg", 16'h8000, 16'h0200, 16'h8000);
    waitDrain();

    // Full streaming vector plus the first element of the next one.
    resetDut();
    last_sum = 16'hDEAD;
    applyStimulus(16'h0100, 16'h0035);
    t0 = cyc;
    for (int i = 1; i < VEC_LEN + 1; i++) applyStimulus(16'h0100, 16'h0035);
    checkOutput("stream_no_gap", 32'(cyc - t0), 32'(VEC_LEN));
    waitDrain();
    checkOutput("vec_sum_const", 32'(last_sum), 32'h0424);

    // Random pairs under random backpressure across three vectors.
    resetDut();
    ready_mode = 1;
    for (int i = 0; i < 3 * VEC_LEN; i++) begin
      g = 16'($urandom_range(0, 16'h0040));
      if ($urandom_range(0, 7) == 0) g = 16'($urandom_range(0, 16'h0400));
      applyStimulus(16'($urandom), g);
      if ($urandom_range(0, 3) == 0) idleCycles(1);
    end
    ready_mode  = 0;
    ready_level = 1'b1;
    waitDrain();

    // Reset with element 7 presented and stage 1 holding element 8.
    resetDut();
    for (int i = 0; i < 9; i++) applyStimulus(16'h0100, 16'h0035);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("pre_reset_idx", 32'(bus.out_idx), 32'd7);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_out_idx", 32'(bus.out_idx), 32'd0);
    checkOutput("mid_rst_sum_valid", 32'(bus.sum_valid), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    checkOutput("mid_rst_no_sum", 32'(bus.sum_valid), 32'd0);

    last_sum   = 16'hDEAD;
    ready_mode = 1;
    for (int i = 0; i < VEC_LEN; i++) applyStimulus(16'h0100, 16'h0035);
    ready_mode  = 0;
    ready_level = 1'b1;
    waitDrain();
    checkOutput("post_rst_vec_sum", 32'(last_sum), 32'h0424);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
